// File: rtl/spi_flash_streamer_if.sv
// Trigger/status, byte stream and flash pin bundle for spi_flash_streamer.
// slave is the streamer side, master is the controller/consumer/board side.
interface spi_flash_streamer_if;
    logic        trigger;
    logic [23:0] addr;
    logic [23:0] len;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        cs_b;
    logic        mosi;
    logic        miso;

    modport slave (
        input  trigger, addr, len, out_ready, miso,
        output busy, done, overflow, out_data, out_valid, cs_b, mosi
    );

    modport master (
        output trigger, addr, len, out_ready, miso,
        input  busy, done, overflow, out_data, out_valid, cs_b, mosi
    );
endinterface

// File: rtl/spi_flash_streamer.sv
// SPI flash READ streamer: shifts {READ_CMD, addr} out, then captures len
// bytes from miso into a small first-word-fall-through FIFO.
module spi_flash_streamer #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         FIFO_AW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_flash_streamer_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_END
    } state_e;

    state_e state_q, state_d;

    logic [31:0]        sh_q, sh_d;
    logic [4:0]         bit_q, bit_d;
    logic [23:0]        rem_q, rem_d;
    logic [7:0]         rx_q, rx_d;
    logic               zdone_q, zdone_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_q, wr_d;
    logic [FIFO_AW-1:0] rd_q, rd_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic       idle_trig;
    logic       accept;
    logic       zero_trig;
    logic       byte_done;
    logic       last_byte;
    logic [7:0] push_byte;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    assign idle_trig = (state_q == S_IDLE) && bus.trigger;
    assign accept    = idle_trig && (bus.len != 24'd0);
    assign zero_trig = idle_trig && (bus.len == 24'd0);
    assign byte_done = (state_q == S_DATA) && (bit_q[2:0] == 3'd7);
    assign last_byte = byte_done && (rem_q == 24'd1);
    assign push_byte = {rx_q[6:0], bus.miso};

    // Count never exceeds DEPTH, so its MSB alone marks full.
    assign empty = (cnt_q == '0);
    assign full  = cnt_q[FIFO_AW];
    assign pop   = !empty && bus.out_ready;
    assign push  = byte_done && (!full || pop);
    assign drop  = byte_done && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_CMD;
            S_CMD:  if (bit_q == 5'd31) state_d = S_DATA;
            S_DATA: if (last_byte) state_d = S_END;
            S_END:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cs_b = 1'b1;
        bus.mosi = 1'b0;
        bus.busy = 1'b0;
        bus.done = zdone_q;
        unique case (state_q)
            S_IDLE: ;
            S_CMD: begin
                bus.cs_b = 1'b0;
                bus.mosi = sh_q[31];
                bus.busy = 1'b1;
            end
            S_DATA: begin
                bus.cs_b = 1'b0;
                bus.busy = 1'b1;
            end
            S_END: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_d    = sh_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        rx_d    = rx_q;
        zdone_d = zero_trig;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d  = {READ_CMD, bus.addr};
                    rem_d = bus.len;
                    bit_d = 5'd0;
                    ovf_d = 1'b0;
                end
            end
            S_CMD: begin
                sh_d  = {sh_q[30:0], 1'b0};
                bit_d = bit_q + 5'd1;
            end
            S_DATA: begin
                rx_d  = push_byte;
                bit_d = bit_q + 5'd1;
                if (byte_done) rem_d = rem_q - 24'd1;
                if (drop) ovf_d = 1'b1;
            end
            S_END: ;
            default: ;
        endcase
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = push_byte;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            rx_q    <= '0;
            zdone_q <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            rx_q    <= rx_d;
            zdone_q <= zdone_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'h00 : mem_q[rd_q];

endmodule

// File: tb/tb_spi_flash_streamer.sv
// Directed bench for spi_flash_streamer with a behavioural SPI flash
// that returns a fixed byte pattern after the 32-bit command.
module tb_spi_flash_streamer;
    logic clk = 1'b0;
    logic rst;

    spi_flash_streamer_if bus ();

    spi_flash_streamer #(
        .READ_CMD (8'h03),
        .FIFO_AW  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic [23:0] len;
        logic [31:0] exp_cmd;
        int          exp_cslow;
        int          exp_busy;
        int          exp_bytes;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]  fdat [8];
    int          fc = 0;
    int          fb;
    logic        miso_v;
    logic [31:0] cmd_sh = '0;
    int          cs_low = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    logic [7:0]  rxq [$];
    int          rxt [$];

    int cs_base, busy_base, done_base, rx_base;

    always_comb begin
        miso_v = 1'b0;
        fb     = 0;
        if (!bus.cs_b && fc >= 32) begin
            fb     = fc - 32;
            miso_v = fdat[(fb / 8) % 8][7 - (fb % 8)];
        end
    end
    assign bus.miso = miso_v;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.cs_b) begin
            if (fc < 32) cmd_sh <= {cmd_sh[30:0], bus.mosi};
            fc     <= fc + 1;
            cs_low <= cs_low + 1;
        end else begin
            fc <= 0;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.out_valid && bus.out_ready) begin
            rxq.push_back(bus.out_data);
            rxt.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] a, input logic [23:0] l);
        bus.addr    = a;
        bus.len     = l;
        bus.trigger = 1'b1;
        cs_base     = cs_low;
        busy_base   = busy_cnt;
        done_base   = done_cnt;
        rx_base     = rxq.size();
        tick(1);
        bus.trigger = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done_cnt > done_base && !bus.busy) && n < budget) begin
            tick(1);
            n++;
        end
        chk("end_seen", 32'(n < budget), 32'd1);
    endtask

    vec_t vt [4];

    initial begin
        fdat[0] = 8'hA5; fdat[1] = 8'h3C; fdat[2] = 8'h5A; fdat[3] = 8'hC3;
        fdat[4] = 8'h01; fdat[5] = 8'h80; fdat[6] = 8'hFF; fdat[7] = 8'h7E;

        vt[0] = '{24'h12E000, 24'd1, 32'h0312E000, 40, 41, 1};
        vt[1] = '{24'h000000, 24'd2, 32'h03000000, 48, 49, 2};
        vt[2] = '{24'hFFFFFF, 24'd3, 32'h03FFFFFF, 56, 57, 3};
        vt[3] = '{24'hA5A5A5, 24'd0, 32'h00000000, 0, 0, 0};

        rst           = 1'b1;
        bus.trigger   = 1'b0;
        bus.addr      = '0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        tick(3);
        chk("rst_cs_b", 32'(bus.cs_b), 32'd1);
        chk("rst_mosi", 32'(bus.mosi), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        tick(2);

        bus.out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            start(vt[v].addr, vt[v].len);
            wait_end(200);
            tick(3);
            if (vt[v].exp_cslow != 0) chk("cmd_word", cmd_sh, vt[v].exp_cmd);
            chk("cs_low", 32'(cs_low - cs_base), 32'(vt[v].exp_cslow));
            chk("busy_len", 32'(busy_cnt - busy_base), 32'(vt[v].exp_busy));
            chk("done_once", 32'(done_cnt - done_base), 32'd1);
            chk("nbytes", 32'(rxq.size() - rx_base), 32'(vt[v].exp_bytes));
            for (int i = 0; i < vt[v].exp_bytes; i++)
                if (rx_base + i < rxq.size())
                    chk("byte", 32'(rxq[rx_base + i]), 32'(fdat[i]));
            if (vt[v].exp_bytes == 2 && rxt.size() >= rx_base + 2)
                chk("spacing", 32'(rxt[rx_base + 1] - rxt[rx_base]), 32'd8);
            chk("ovf_clear", 32'(bus.overflow), 32'd0);
            chk("busy_low", 32'(bus.busy), 32'd0);
        end

        // Consumer stalled across a 6-byte read
        bus.out_ready = 1'b0;
        start(24'h000040, 24'd6);
        wait_end(200);
        tick(2);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_ovf", 32'(bus.overflow), 32'd1);
        chk("bp_head", 32'(bus.out_data), 32'hA5);
        chk("bp_none", 32'(rxq.size() - rx_base), 32'd0);
        bus.out_ready = 1'b1;
        tick(6);
        chk("bp_count", 32'(rxq.size() - rx_base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rx_base + i < rxq.size())
                chk("bp_byte", 32'(rxq[rx_base + i]), 32'(fdat[i]));
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        chk("bp_sticky", 32'(bus.overflow), 32'd1);

        // Full FIFO popped exactly on the 5th push edge (E0+72)
        bus.out_ready = 1'b0;
        start(24'h000080, 24'd5);
        tick(71);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        chk("fp_ovf", 32'(bus.overflow), 32'd0);
        chk("fp_one", 32'(rxq.size() - rx_base), 32'd1);
        wait_end(200);
        bus.out_ready = 1'b1;
        tick(6);
        chk("fp_count", 32'(rxq.size() - rx_base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (rx_base + i < rxq.size())
                chk("fp_byte", 32'(rxq[rx_base + i]), 32'(fdat[i]));
        chk("fp_ovf_end", 32'(bus.overflow), 32'd0);

        // Trigger during CMD must be ignored
        start(24'h000100, 24'd3);
        tick(10);
        bus.len     = 24'd1;
        bus.trigger = 1'b1;
        tick(1);
        bus.trigger = 1'b0;
        wait_end(200);
        tick(3);
        chk("bt_bytes", 32'(rxq.size() - rx_base), 32'd3);
        chk("bt_cslow", 32'(cs_low - cs_base), 32'd56);
        chk("bt_done", 32'(done_cnt - done_base), 32'd1);

        // Reset at DATA bit 13 of a len=4 read
        bus.out_ready = 1'b0;
        start(24'h000200, 24'd4);
        tick(45);
        chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("mr_pre_cs", 32'(bus.cs_b), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("mr_cs_b", 32'(bus.cs_b), 32'd1);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_ovf", 32'(bus.overflow), 32'd0);
        chk("mr_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        tick(2);
        bus.out_ready = 1'b1;
        start(24'h000300, 24'd2);
        wait_end(200);
        tick(3);
        chk("mr_bytes", 32'(rxq.size() - rx_base), 32'd2);
        for (int i = 0; i < 2; i++)
            if (rx_base + i < rxq.size())
                chk("mr_byte", 32'(rxq[rx_base + i]), 32'(fdat[i]));
        chk("mr_done", 32'(done_cnt - done_base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
